// File: rtl/vx_dcache_responder.sv
// rtl/vx_dcache_responder.sv - batched multi-lane word cache responder (IDLE/SERVE/RESP)
// Optional feature macro: VX_RSP_DUP_MERGE_EN (all-read same-address batches served in one cycle)
module vx_dcache_responder #(
   parameter int NUM_LANES = 4,
   parameter int DEPTH     = 1024,
   parameter int TAG_WIDTH = 8
) (
   input  logic                           clk_i,
   input  logic                           reset_ni,
   input  logic [NUM_LANES-1:0]           req_valid_i,
   input  logic [NUM_LANES-1:0]           req_rw_i,
   output logic [NUM_LANES-1:0]           req_ready_o,
   input  logic [NUM_LANES*30-1:0]        req_addr_i,
   input  logic [NUM_LANES*4-1:0]         req_byteen_i,
   input  logic [NUM_LANES*32-1:0]        req_data_i,
   input  logic [NUM_LANES*TAG_WIDTH-1:0] req_tag_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [NUM_LANES-1:0]           rsp_tmask_o,
   output logic [NUM_LANES*32-1:0]        rsp_data_o,
   output logic [TAG_WIDTH-1:0]           rsp_tag_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

   state_t                         state_q, state_d;
   logic [NUM_LANES-1:0]           pend_q, pend_d;
   logic [NUM_LANES-1:0]           rw_q, rw_d;
   logic [NUM_LANES*30-1:0]        addr_q, addr_d;
   logic [NUM_LANES*4-1:0]         byteen_q, byteen_d;
   logic [NUM_LANES*32-1:0]        wdata_q, wdata_d;
   logic                           merge_q, merge_d;
   logic [NUM_LANES-1:0]           rsp_tmask_q, rsp_tmask_d;
   logic [NUM_LANES*32-1:0]        rsp_data_q, rsp_data_d;
   logic [TAG_WIDTH-1:0]           rsp_tag_q, rsp_tag_d;

   // Word storage; deliberately has no reset so writes survive an aborted batch.
   logic [31:0]                    mem_q [DEPTH];

   logic [LW-1:0]                  sel;
   logic                           any_pend;
   logic [LW-1:0]                  first_valid;
   logic                           cap_merge;
   logic [AW-1:0]                  mem_idx;
   logic [31:0]                    mem_rdata;
   logic [31:0]                    mem_wdata;
   logic                           mem_we;

   // Lowest-index pending lane: the lane served this SERVE cycle.
   always_comb begin
      sel      = '0;
      any_pend = 1'b0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            sel      = LW'(i);
            any_pend = 1'b1;
         end
      end
   end

   // Lowest-index valid request lane: supplies the batch tag.
   always_comb begin
      first_valid = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (req_valid_i[i]) first_valid = LW'(i);
      end
   end

`ifdef VX_RSP_DUP_MERGE_EN
   // A batch is mergeable when every valid lane reads the same full address.
   always_comb begin
      cap_merge = 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (req_valid_i[i] &&
             (req_rw_i[i] || (req_addr_i[i*30 +: 30] != req_addr_i[first_valid*30 +: 30]))) begin
            cap_merge = 1'b0;
         end
      end
   end
`else
   assign cap_merge = 1'b0;
`endif

   assign mem_idx   = addr_q[sel*30 +: AW];
   assign mem_rdata = mem_q[mem_idx];

   // Byte-merge the served lane's write data over the current word.
   always_comb begin
      mem_wdata = mem_rdata;
      for (int b = 0; b < 4; b++) begin
         if (byteen_q[sel*4 + b]) mem_wdata[b*8 +: 8] = wdata_q[sel*32 + b*8 +: 8];
      end
   end

   // Next-state and per-cycle lane servicing.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      byteen_d    = byteen_q;
      wdata_d     = wdata_q;
      merge_d     = merge_q;
      rsp_tmask_d = rsp_tmask_q;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      req_ready_o = '0;
      mem_we      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = '1;
            if (|req_valid_i) begin
               pend_d      = req_valid_i;
               rw_d        = req_rw_i;
               addr_d      = req_addr_i;
               byteen_d    = req_byteen_i;
               wdata_d     = req_data_i;
               merge_d     = cap_merge;
               rsp_tmask_d = '0;
               rsp_data_d  = '0;
               rsp_tag_d   = req_tag_i[first_valid*TAG_WIDTH +: TAG_WIDTH];
               state_d     = SERVE;
            end
         end
         SERVE: begin
            if (!any_pend) begin
               // Extra cycle after the last lane decides whether a response exists.
               state_d = (|rsp_tmask_q) ? RESP : IDLE;
            end else if (merge_q) begin
               rsp_tmask_d = pend_q;
               for (int i = 0; i < NUM_LANES; i++) begin
                  if (pend_q[i]) rsp_data_d[i*32 +: 32] = mem_rdata;
               end
               pend_d = '0;
            end else begin
               pend_d[sel] = 1'b0;
               if (rw_q[sel]) begin
                  mem_we = 1'b1;
               end else begin
                  rsp_tmask_d[sel]          = 1'b1;
                  rsp_data_d[sel*32 +: 32] = mem_rdata;
               end
            end
         end
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and response registers; reset aborts any batch in flight.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         rw_q        <= '0;
         addr_q      <= '0;
         byteen_q    <= '0;
         wdata_q     <= '0;
         merge_q     <= 1'b0;
         rsp_tmask_q <= '0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         byteen_q    <= byteen_d;
         wdata_q     <= wdata_d;
         merge_q     <= merge_d;
         rsp_tmask_q <= rsp_tmask_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
      end
   end

   // Storage write port.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[mem_idx] <= mem_wdata;
   end

   assign rsp_valid_o = (state_q == RESP);
   assign rsp_tmask_o = rsp_tmask_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_tag_o   = rsp_tag_q;

endmodule

// File: tb/tb_vx_dcache_responder.sv
// tb/tb_vx_dcache_responder.sv - self-checking bench for vx_dcache_responder
module tb_vx_dcache_responder;

   localparam int DEPTH = 1024;

   logic          clk;
   logic          rst_n;
   logic [3:0]    req_valid_i;
   logic [3:0]    req_rw_i;
   logic [3:0]    req_ready_o;
   logic [119:0]  req_addr_i;
   logic [15:0]   req_byteen_i;
   logic [127:0]  req_data_i;
   logic [31:0]   req_tag_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [3:0]    rsp_tmask_o;
   logic [127:0]  rsp_data_o;
   logic [7:0]    rsp_tag_o;

   vx_dcache_responder #(.NUM_LANES(4), .DEPTH(DEPTH), .TAG_WIDTH(8)) dut (
      .clk_i        (clk),
      .reset_ni     (rst_n),
      .req_valid_i  (req_valid_i),
      .req_rw_i     (req_rw_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .req_byteen_i (req_byteen_i),
      .req_data_i   (req_data_i),
      .req_tag_i    (req_tag_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_tmask_o  (rsp_tmask_o),
      .rsp_data_o   (rsp_data_o),
      .rsp_tag_o    (rsp_tag_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]       valid;
      logic [3:0]       rw;
      logic [3:0][29:0] addr;
      logic [3:0][3:0]  be;
      logic [3:0][31:0] data;
      logic [3:0][7:0]  tag;
      logic             exp_rsp;
      logic [3:0]       exp_tmask;
      logic [3:0][31:0] exp_data;
      logic [7:0]       exp_tag;
      int               exp_lat;
      int               hold;
   } vec_t;

   int          checks = 0;
   int          errs   = 0;
   logic [31:0] ref_mem [DEPTH];
   logic [9:0]  pool [8];
   vec_t        tbl [8];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t ln(input vec_t v, input int l, input logic rw, input logic [29:0] a,
                               input logic [3:0] be, input logic [31:0] d, input logic [7:0] t);
      v.valid[l] = 1'b1;
      v.rw[l]    = rw;
      v.addr[l]  = a;
      v.be[l]    = be;
      v.data[l]  = d;
      v.tag[l]   = t;
      return v;
   endfunction

   // Reference: lanes applied in index order to a plain word array.
   function automatic vec_t model(input vec_t v);
      int k = 0;
      int first = -1;
      bit same_rd = 1'b1;
      int idx;
      v.exp_tmask = '0;
      v.exp_data  = '0;
      v.exp_tag   = '0;
      for (int l = 0; l < 4; l++) begin
         if (v.valid[l]) begin
            k++;
            if (first < 0) begin
               first = l;
               v.exp_tag = v.tag[l];
            end
            idx = int'(v.addr[l]) % DEPTH;
            if (v.rw[l]) begin
               for (int b = 0; b < 4; b++)
                  if (v.be[l][b]) ref_mem[idx][b*8 +: 8] = v.data[l][b*8 +: 8];
            end else begin
               v.exp_tmask[l] = 1'b1;
               v.exp_data[l]  = ref_mem[idx];
            end
            if (v.rw[l] || v.addr[l] != v.addr[first]) same_rd = 1'b0;
         end
      end
      v.exp_rsp = |v.exp_tmask;
      v.exp_lat = k + 1;
`ifdef VX_RSP_DUP_MERGE_EN
      if (same_rd) v.exp_lat = 2;
`endif
      return v;
   endfunction

   task automatic run_batch(input vec_t v, input bit early, input string nm);
      int n;
      bit seen;
      @(negedge clk);
      chk({nm, " idle_ready"}, 128'(req_ready_o), 128'(4'hF));
      req_valid_i  = v.valid;
      req_rw_i     = v.rw;
      req_addr_i   = v.addr;
      req_byteen_i = v.be;
      req_data_i   = v.data;
      req_tag_i    = v.tag;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = '0;
      rsp_ready_i = early;
      chk({nm, " busy_ready"}, 128'(req_ready_o), 128'(0));
      seen = 1'b0;
      n = 0;
      while (!seen && n < v.exp_lat + 4) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (rsp_valid_o) seen = 1'b1;
      end
      if (!v.exp_rsp) begin
         chk({nm, " no_rsp"}, 128'(seen), 128'(0));
         chk({nm, " ready_after"}, 128'(req_ready_o), 128'(4'hF));
      end else begin
         chk({nm, " latency"}, 128'(n), 128'(v.exp_lat));
         chk({nm, " tmask"}, 128'(rsp_tmask_o), 128'(v.exp_tmask));
         chk({nm, " data"}, rsp_data_o, v.exp_data);
         chk({nm, " tag"}, 128'(rsp_tag_o), 128'(v.exp_tag));
         for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk({nm, " hold_valid"}, 128'(rsp_valid_o), 128'(1));
            chk({nm, " hold_data"}, rsp_data_o, v.exp_data);
            chk({nm, " hold_tag"}, 128'({rsp_tmask_o, rsp_tag_o}), 128'({v.exp_tmask, v.exp_tag}));
            chk({nm, " hold_ready"}, 128'(req_ready_o), 128'(0));
         end
         rsp_ready_i = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk({nm, " rsp_done"}, 128'(rsp_valid_o), 128'(0));
         chk({nm, " idle_after"}, 128'(req_ready_o), 128'(4'hF));
      end
      rsp_ready_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      vec_t m;
      rst_n        = 1'b0;
      req_valid_i  = '0;
      req_rw_i     = '0;
      req_addr_i   = '0;
      req_byteen_i = '0;
      req_data_i   = '0;
      req_tag_i    = '0;
      rsp_ready_i  = 1'b0;

      // Directed vector table.
      for (int i = 0; i < 8; i++) tbl[i] = '0;
      tbl[0] = ln(tbl[0], 0, 1'b1, 30'h10, 4'hF, 32'hDEADBEEF, 8'h11);
      tbl[0].exp_lat = 2;
      tbl[1] = ln(tbl[1], 2, 1'b0, 30'h10, 4'h0, 32'h0, 8'h5A);
      tbl[1].exp_rsp = 1'b1; tbl[1].exp_tmask = 4'b0100; tbl[1].exp_data[2] = 32'hDEADBEEF;
      tbl[1].exp_tag = 8'h5A; tbl[1].exp_lat = 2;
      tbl[2] = ln(tbl[2], 0, 1'b1, 30'h20, 4'hF, 32'hAAAAAAAA, 8'h01);
      tbl[2] = ln(tbl[2], 1, 1'b1, 30'h40, 4'hF, 32'h12345678, 8'h02);
      tbl[2] = ln(tbl[2], 2, 1'b1, 30'h400, 4'hF, 32'h00000055, 8'h03);
      tbl[2].exp_lat = 4;
      tbl[3] = ln(tbl[3], 1, 1'b1, 30'h20, 4'h3, 32'h11223344, 8'h21);
      tbl[3] = ln(tbl[3], 3, 1'b0, 30'h20, 4'h0, 32'h0, 8'h23);
      tbl[3].exp_rsp = 1'b1; tbl[3].exp_tmask = 4'b1000; tbl[3].exp_data[3] = 32'hAAAA3344;
      tbl[3].exp_tag = 8'h21; tbl[3].exp_lat = 3;
      for (int l = 0; l < 4; l++) begin
         tbl[4] = ln(tbl[4], l, 1'b0, 30'h40, 4'h0, 32'h0, 8'(8'h30 + l));
         tbl[4].exp_data[l] = 32'h12345678;
      end
      tbl[4].exp_rsp = 1'b1; tbl[4].exp_tmask = 4'hF; tbl[4].exp_tag = 8'h30; tbl[4].hold = 5;
`ifdef VX_RSP_DUP_MERGE_EN
      tbl[4].exp_lat = 2;
`else
      tbl[4].exp_lat = 5;
`endif
      tbl[5] = ln(tbl[5], 0, 1'b0, 30'h000, 4'h0, 32'h0, 8'h77);
      tbl[5].exp_rsp = 1'b1; tbl[5].exp_tmask = 4'b0001; tbl[5].exp_data[0] = 32'h00000055;
      tbl[5].exp_tag = 8'h77; tbl[5].exp_lat = 2;
      tbl[6] = ln(tbl[6], 0, 1'b1, 30'h50, 4'hF, 32'hCAFEF00D, 8'h60);
      tbl[6] = ln(tbl[6], 1, 1'b0, 30'h50, 4'h0, 32'h0, 8'h61);
      tbl[6] = ln(tbl[6], 2, 1'b1, 30'h50, 4'h8, 32'h99000000, 8'h62);
      tbl[6] = ln(tbl[6], 3, 1'b0, 30'h50, 4'h0, 32'h0, 8'h63);
      tbl[6].exp_rsp = 1'b1; tbl[6].exp_tmask = 4'b1010;
      tbl[6].exp_data[1] = 32'hCAFEF00D; tbl[6].exp_data[3] = 32'h99FEF00D;
      tbl[6].exp_tag = 8'h60; tbl[6].exp_lat = 5;
      tbl[7] = ln(tbl[7], 0, 1'b0, 30'h10, 4'h0, 32'h0, 8'h42);
      tbl[7] = ln(tbl[7], 2, 1'b0, 30'h40, 4'h0, 32'h0, 8'h43);
      tbl[7].exp_rsp = 1'b1; tbl[7].exp_tmask = 4'b0101;
      tbl[7].exp_data[0] = 32'hDEADBEEF; tbl[7].exp_data[2] = 32'h12345678;
      tbl[7].exp_tag = 8'h42; tbl[7].exp_lat = 3;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset rsp_valid", 128'(rsp_valid_o), 128'(0));
      chk("reset rsp_fields", {rsp_data_o}, 128'(0));
      chk("reset tmask_tag", 128'({rsp_tmask_o, rsp_tag_o}), 128'(0));
      rst_n = 1'b1;
      chk("reset first ready", 128'(req_ready_o), 128'(4'hF));

      for (int i = 0; i < 8; i++) begin
         m = model(tbl[i]);
         run_batch(tbl[i], 1'b0, $sformatf("vec%0d", i));
      end

      // Reset during SERVE: the lane0 write already done must persist.
      v = '0;
      v = ln(v, 0, 1'b1, 30'h60, 4'hF, 32'h0BADF00D, 8'h90);
      for (int l = 1; l < 4; l++) v = ln(v, l, 1'b0, 30'h10, 4'h0, 32'h0, 8'(8'h90 + l));
      @(negedge clk);
      req_valid_i = v.valid; req_rw_i = v.rw; req_addr_i = v.addr;
      req_byteen_i = v.be; req_data_i = v.data; req_tag_i = v.tag;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = '0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid rsp_valid", 128'(rsp_valid_o), 128'(0));
      chk("rst_mid rsp_data", rsp_data_o, 128'(0));
      chk("rst_mid tmask_tag", 128'({rsp_tmask_o, rsp_tag_o}), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mid ready", 128'(req_ready_o), 128'(4'hF));
      rsp_ready_i = 1'b1;
      begin
         bit any_v = 1'b0;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid_o) any_v = 1'b1;
         end
         chk("rst_mid dropped", 128'(any_v), 128'(0));
      end
      rsp_ready_i = 1'b0;
      chk("rst_mid rsp_after", 128'({rsp_tmask_o, rsp_tag_o}), 128'(0));
      ref_mem[32'h60] = 32'h0BADF00D;
      v = '0;
      v = ln(v, 3, 1'b0, 30'h60, 4'h0, 32'h0, 8'hA5);
      v = model(v);
      run_batch(v, 1'b0, "rst_persist");

      // Random phase: prefill a pool of words, then random batches.
      for (int k = 0; k < 8; k++) pool[k] = 10'(10'h100 + 3 * k);
      for (int p = 0; p < 2; p++) begin
         v = '0;
         for (int l = 0; l < 4; l++)
            v = ln(v, l, 1'b1, {20'($urandom), pool[p*4 + l]}, 4'hF, $urandom, 8'($urandom));
         v = model(v);
         run_batch(v, 1'b0, "prefill");
      end
      for (int it = 0; it < 40; it++) begin
         bit early;
         v = '0;
         if ($urandom_range(0, 3) == 0) begin
            logic [29:0] a;
            a = {20'($urandom), pool[$urandom_range(0, 7)]};
            for (int l = 0; l < 4; l++)
               if ($urandom_range(0, 1) == 1 || l == 3) v = ln(v, l, 1'b0, a, 4'h0, 32'h0, 8'($urandom));
         end else begin
            for (int l = 0; l < 4; l++)
               if ($urandom_range(0, 2) != 0)
                  v = ln(v, l, 1'($urandom), {20'($urandom), pool[$urandom_range(0, 7)]},
                         4'($urandom), $urandom, 8'($urandom));
            if (v.valid == 4'h0) v = ln(v, 0, 1'b0, {20'h0, pool[0]}, 4'h0, 32'h0, 8'hEE);
         end
         early = 1'($urandom);
         v = model(v);
         v.hold = early ? 0 : int'($urandom_range(0, 2));
         run_batch(v, early, $sformatf("rand%0d", it));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
